// File: rtl/uart_reg_bank_pkg.sv
// Shared types and sizing helpers for the UART-addressed register bank.
package uart_reg_bank_pkg;

  // Packet-assembly FSM states, encoded exactly as exported on the state port.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  // Number of data bytes in one register word.
  function automatic int bytes_of(input int wordsz);
    return wordsz / 8;
  endfunction

  // Width of a register index; never narrower than one bit.
  function automatic int idxw_of(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  // Width of the per-packet byte counter; never narrower than one bit.
  function automatic int cntw_of(input int nbytes);
    return (nbytes > 2) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, one-cycle valid and break pulses.
module uart_rx #(
  parameter int BIT_RATE     = 9_600,
  parameter int CLK_HZ       = 100_000_000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rxd_i,
  output logic                    rx_valid_o,
  output logic                    rx_break_o,
  output logic [PAYLOAD_BITS-1:0] rx_data_o
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB + 1);
  localparam int BW   = (PAYLOAD_BITS > 2) ? $clog2(PAYLOAD_BITS) : 1;

  // WAIT holds after a break or framing error until the line returns high.
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;

  rx_state_e               st_q, st_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] sr_q, sr_d;
  logic                    valid_q, valid_d;
  logic                    break_q, break_d;
  logic [1:0]              sync_q;
  logic                    rxd_s;

  assign rxd_s      = sync_q[1];
  assign rx_valid_o = valid_q;
  assign rx_break_o = break_q;
  assign rx_data_o  = sr_q;

  // Two-flop synchroniser for the asynchronous RX pin, idling high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rxd_i};
  end

  // Frame sequencer: next state, bit timing and output pulses.
  // NOTE: combinational blocks use blocking '=' with every target defaulted first, so no latch is inferred.
  always_comb begin
    st_d    = st_q;
    tick_d  = tick_q + TW'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    valid_d = 1'b0;
    break_d = 1'b0;
    case (st_q)
      R_IDLE: begin
        tick_d = '0;
        if (!rxd_s) st_d = R_START;
      end
      R_START: if (tick_q == TW'(HALF - 1)) begin
        tick_d = '0;
        bit_d  = '0;
        st_d   = rxd_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (tick_q == TW'(CPB - 1)) begin
        tick_d = '0;
        sr_d   = {rxd_s, sr_q[PAYLOAD_BITS-1:1]};
        if (bit_q == BW'(PAYLOAD_BITS - 1)) st_d = R_STOP;
        else                                bit_d = bit_q + BW'(1);
      end
      R_STOP: if (tick_q == TW'(CPB - 1)) begin
        tick_d = '0;
        if (rxd_s) begin
          valid_d = 1'b1;
          st_d    = R_IDLE;
        end else begin
          break_d = (sr_q == '0);
          st_d    = R_WAIT;
        end
      end
      R_WAIT: begin
        tick_d = '0;
        if (rxd_s) st_d = R_IDLE;
      end
      default: st_d = R_IDLE;
    endcase
  end

  // Receiver state registers.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q    <= R_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      valid_q <= 1'b0;
      break_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
      break_q <= break_d;
    end
  end

endmodule

// File: rtl/uart_reg_bank.sv
// Register bank written by UART packets: index byte, then WORDSZ/8 data bytes MSB first.
module uart_reg_bank
  import uart_reg_bank_pkg::*;
#(
  parameter int WORDSZ      = 16,
  parameter int NREGS       = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int BIT_RATE    = 9_600,
  parameter int TIMEOUT_CYC = 20 * CLK_HZ / BIT_RATE
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_rxd,
  input  logic                       rx_en,
  output logic [NREGS*WORDSZ-1:0]    regs,
  output logic                       wr_pulse,
  output logic [idxw_of(NREGS)-1:0]  wr_idx,
  output logic                       err_addr,
  output logic                       err_timeout,
  output logic [1:0]                 state
);

  localparam int BYTES = bytes_of(WORDSZ);
  localparam int IDXW  = idxw_of(NREGS);
  localparam int CNTW  = cntw_of(BYTES);
  localparam int GW    = $clog2(TIMEOUT_CYC + 1);
  // Shadow holds the leading bytes; kept at least 8 bits wide so WORDSZ=8 still elaborates.
  localparam int SHW   = (WORDSZ > 8) ? WORDSZ - 8 : 8;

  logic             rx_rstn, rx_valid, rx_break;
  logic [7:0]       rx_data;
  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IDXW-1:0]  idx_q, idx_d, wr_idx_q;
  logic [SHW-1:0]   shadow_q, shadow_d;
  logic [SHW+7:0]   cat;
  logic [WORDSZ-1:0] regs_q [NREGS];
  logic             wr_en, idx_ok, cnt_last;
  logic             wr_pulse_q, wr_pulse_d, err_addr_q, err_addr_d, err_to_q, err_to_d;

  // Receiver is held in reset while reception is disabled.
  assign rx_rstn = resetn & rx_en;

  uart_rx #(
    .BIT_RATE     (BIT_RATE),
    .CLK_HZ       (CLK_HZ),
    .PAYLOAD_BITS (8)
  ) u_rx (
    .clk        (clk),
    .resetn     (rx_rstn),
    .rxd_i      (uart_rxd),
    .rx_valid_o (rx_valid),
    .rx_break_o (rx_break),
    .rx_data_o  (rx_data)
  );

  assign cat         = {shadow_q, rx_data};
  assign idx_ok      = int'(rx_data) < NREGS;
  assign cnt_last    = (cnt_q == CNTW'(BYTES - 1));
  assign wr_pulse    = wr_pulse_q;
  assign wr_idx      = wr_idx_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_to_q;
  assign state       = state_q;

  // Packet FSM: priority rx_en low > break > valid byte > timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = (state_q == S_IDLE) ? '0 : gap_q + GW'(1);
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    wr_en      = 1'b0;
    wr_pulse_d = 1'b0;
    err_addr_d = 1'b0;
    err_to_d   = 1'b0;
    if (!rx_en || rx_break) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gap_d   = '0;
    end else if (rx_valid) begin
      gap_d = '0;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (idx_ok) begin
            idx_d   = rx_data[IDXW-1:0];
            state_d = S_DATA;
          end else begin
            err_addr_d = 1'b1;
            state_d    = S_DISCARD;
          end
        end
        S_DATA: begin
          if (cnt_last) begin
            wr_en      = 1'b1;
            wr_pulse_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            shadow_d = cat[SHW-1:0];
            cnt_d    = cnt_q + CNTW'(1);
          end
        end
        S_DISCARD: begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && gap_q == GW'(TIMEOUT_CYC)) begin
      err_to_d = 1'b1;
      state_d  = S_IDLE;
      cnt_d    = '0;
      gap_d    = '0;
      shadow_d = '0;
    end
  end

  // FSM state, counters, shadow and one-cycle strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      wr_pulse_q <= 1'b0;
      err_addr_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      wr_pulse_q <= wr_pulse_d;
      err_addr_q <= err_addr_d;
      err_to_q   <= err_to_d;
    end
  end

  // Register array and last-written index; new data lands with wr_pulse.
  // NOTE: the array is reset entry by entry because its contents are live outputs, so it must be flops, not RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wr_idx_q <= '0;
    end else if (wr_en) begin
      regs_q[idx_q] <= cat[WORDSZ-1:0];
      wr_idx_q      <= idx_q;
    end
  end

  // Flatten the array onto the output bus, register i at [i*WORDSZ +: WORDSZ].
  always_comb begin
    regs = '0;
    for (int i = 0; i < NREGS; i++) regs[i*WORDSZ +: WORDSZ] = regs_q[i];
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Scoreboard bench for uart_reg_bank: directed scenarios plus random packets.
module tb_uart_reg_bank;

  localparam int WORDSZ   = 16;
  localparam int NREGS    = 4;
  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int TIMEOUT  = 20 * CLK_HZ / BIT_RATE;

  typedef enum int {EV_WR = 0, EV_ADDR = 1, EV_TO = 2} ev_kind_e;
  typedef struct {
    ev_kind_e          kind;
    int                idx;
    logic [WORDSZ-1:0] data;
  } ev_t;

  logic                    clk = 1'b0;
  logic                    resetn, uart_rxd, rx_en;
  logic [NREGS*WORDSZ-1:0] regs;
  logic                    wr_pulse, err_addr, err_timeout;
  logic [1:0]              wr_idx;
  logic [1:0]              state;

  int                n_checks = 0;
  int                n_errors = 0;
  ev_t               exp_q[$];
  logic [WORDSZ-1:0] mdl_regs [NREGS];

  uart_reg_bank #(
    .WORDSZ   (WORDSZ),
    .NREGS    (NREGS),
    .CLK_HZ   (CLK_HZ),
    .BIT_RATE (BIT_RATE)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .uart_rxd    (uart_rxd),
    .rx_en       (rx_en),
    .regs        (regs),
    .wr_pulse    (wr_pulse),
    .wr_idx      (wr_idx),
    .err_addr    (err_addr),
    .err_timeout (err_timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREGS*WORDSZ-1:0] mdl_flat();
    logic [NREGS*WORDSZ-1:0] r;
    for (int i = 0; i < NREGS; i++) r[i*WORDSZ +: WORDSZ] = mdl_regs[i];
    return r;
  endfunction

  // Monitor: every strobe consumes one expected event and the bus is compared to the model.
  always @(negedge clk) begin
    ev_kind_e seen;
    ev_t      e;
    if (resetn && (wr_pulse || err_addr || err_timeout)) begin
      seen = wr_pulse ? EV_WR : (err_addr ? EV_ADDR : EV_TO);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got kind %0d, expected no strobe", seen);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 64'(seen), 64'(e.kind));
        if (e.kind == EV_WR) begin
          mdl_regs[e.idx] = e.data;
          check("wr_idx", 64'(wr_idx), 64'(e.idx));
          check("wr_word", 64'(regs[e.idx*WORDSZ +: WORDSZ]), 64'(e.data));
        end
        check("regs_bus", 64'(regs), 64'(mdl_flat()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Expected outcome follows the packet rules: index in range writes, else an address error.
  task automatic send_pkt(input logic [7:0] idx, input logic [15:0] data, input int gap);
    ev_t e;
    e.idx  = int'(idx);
    e.data = data;
    e.kind = (int'(idx) < NREGS) ? EV_WR : EV_ADDR;
    exp_q.push_back(e);
    send_byte(idx);
    repeat (gap) @(negedge clk);
    send_byte(data[15:8]);
    repeat (gap) @(negedge clk);
    send_byte(data[7:0]);
  endtask

  task automatic push_timeout();
    ev_t e;
    e.kind = EV_TO;
    e.idx  = 0;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic send_break();
    uart_rxd = 1'b0;
    repeat (11 * CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ridx;
    logic [15:0] rdata;
    for (int i = 0; i < NREGS; i++) mdl_regs[i] = '0;
    resetn   = 1'b1;
    uart_rxd = 1'b1;
    rx_en    = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check("rst_regs", 64'(regs), 64'd0);
    check("rst_wr_idx", 64'(wr_idx), 64'd0);
    check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_state", 64'(state), 64'd0);

    // Plain write.
    send_pkt(8'h02, 16'hABCD, 0);
    wait_drain("drain_basic");

    // Out-of-range index is discarded, next packet back to back.
    send_pkt(8'h07, 16'h1122, 0);
    send_pkt(8'h00, 16'h5AA5, 0);
    wait_drain("drain_addr");

    // Inter-byte timeout aborts the packet.
    push_timeout();
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TIMEOUT + 100) @(negedge clk);
    check("state_after_timeout", 64'(state), 64'd0);
    wait_drain("drain_timeout");
    send_pkt(8'h01, 16'h3456, 0);
    wait_drain("drain_after_timeout");

    // Break mid-packet: silent return to IDLE.
    send_byte(8'h03);
    send_byte(8'h99);
    send_break();
    check("state_after_break", 64'(state), 64'd0);
    send_pkt(8'h03, 16'h7788, 0);
    wait_drain("drain_break");

    // rx_en low forces IDLE while held.
    send_byte(8'h02);
    send_byte(8'hEE);
    check("state_in_data", 64'(state), 64'd1);
    rx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("state_rx_en_low", 64'(state), 64'd0);
    end
    rx_en = 1'b1;
    repeat (2) @(negedge clk);
    send_pkt(8'h02, 16'h1020, 0);
    wait_drain("drain_rx_en");

    // Random packets with random inter-byte gaps below the timeout.
    for (int n = 0; n < 24; n++) begin
      ridx  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
      rdata = 16'($urandom);
      send_pkt(ridx, rdata, int'($urandom_range(0, 40)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    wait_drain("drain_random");

    // Reset in the middle of a packet clears everything asynchronously.
    send_pkt(8'h01, 16'hBEEF, 0);
    wait_drain("drain_beef");
    send_byte(8'h01);
    uart_rxd = 1'b0;
    repeat (15) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) mdl_regs[i] = '0;
    check("mid_rst_regs", 64'(regs), 64'd0);
    check("mid_rst_wr_idx", 64'(wr_idx), 64'd0);
    check("mid_rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check("mid_rst_err_addr", 64'(err_addr), 64'd0);
    check("mid_rst_err_timeout", 64'(err_timeout), 64'd0);
    check("mid_rst_state", 64'(state), 64'd0);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("post_rst_regs", 64'(regs), 64'd0);

    // Recovery after reset.
    send_pkt(8'h01, 16'h0F0F, 0);
    wait_drain("drain_recovery");
    check("final_regs", 64'(regs), 64'(mdl_flat()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
